uart_receiver: RTL and testbench

Full 8N1 UART receiver, the listening end of the serial link our transmitter drives on SER_TX. It synchronizes the asynchronous line and samples each bit at its midpoint. It rejects start-bit glitches and checks the stop bit. Each received byte is held in a one-entry output register with a valid/ready handshake. It replaces ad-hoc loopback decoding and feeds message checkers and LED/debug logic in the same ser_clk domain.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_sync2.sv | 20 ++
 rtl/uart_receiver.sv | 85 ++++++++
 tb/tb_uart_receiver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and helpers for the transmitter and receiver
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_e;
    localparam int bits_per_frame = 10;
    function automatic int timer_width(input int cpb);
        return $clog2(cpb);
    endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer with configurable reset value
module uart_sync2 #(
    parameter logic rst_val = 1'b1
) (
    input  logic ser_clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge ser_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver with mid-bit sampling, glitch rejection and a one-entry output register
module uart_receiver
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 4
) (
    input  logic       ser_clk,
    input  logic       rst_n,
    input  logic       ser_rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clear,
    output logic       rx_busy
);
    localparam int tw = timer_width(clocks_per_bit);
    localparam logic [tw-1:0] t_half = tw'(clocks_per_bit / 2 - 1);
    localparam logic [tw-1:0] t_full = tw'(clocks_per_bit - 1);
    logic          rx_s;
    rx_state_e     state;
    logic [tw-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tick, stop_ok, stop_bad, deliver, drop;
    uart_sync2 #(.rst_val(1'b1)) u_sync (
        .ser_clk(ser_clk),
        .rst_n  (rst_n),
        .d      (ser_rx),
        .q      (rx_s)
    );
    always_comb begin
        tick     = timer == '0;
        stop_ok  = state == STOP && tick && rx_s;
        stop_bad = state == STOP && tick && !rx_s;
        deliver  = stop_ok && (!out_valid || out_ready);
        drop     = stop_ok && out_valid && !out_ready;
        rx_busy  = state != IDLE;
    end
    always_ff @(posedge ser_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    timer <= t_half;
                end
                START: if (!tick) timer <= timer - 1'b1;
                else if (rx_s) state <= IDLE;
                else begin
                    state   <= DATA;
                    timer   <= t_full;
                    bit_idx <= '0;
                end
                DATA: if (!tick) timer <= timer - 1'b1;
                else begin
                    shift   <= {rx_s, shift[7:1]};
                    timer   <= t_full;
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= STOP;
                end
                STOP: if (!tick) timer <= timer - 1'b1;
                else state <= rx_s ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
            // a byte completing during an accept cycle replaces the one leaving
            if (deliver) begin
                out_data  <= shift;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) out_valid <= 1'b0;
            frame_err <= stop_bad | (frame_err & ~err_clear);
            overrun   <= drop | (overrun & ~err_clear);
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames checked against a timing-rule model of the receiver
module tb_uart_receiver;
    localparam int CPB = 4;
    localparam int H = CPB / 2;
    logic ser_clk = 1'b0, rst_n = 1'b0, ser_rx = 1'b1, out_ready = 1'b1, err_clear = 1'b0;
    logic [7:0] out_data;
    logic out_valid, frame_err, overrun, rx_busy;
    int passed = 0, total = 0, cyc = 0;
    int valid_rises = 0, last_rise = -1, last_busy_fall = -1;
    logic [7:0] rx_q[$];
    int m_mode = 0, m_t = 0;
    logic m_d1 = 1'b1, m_d2 = 1'b1, m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
    logic [7:0] m_data = 8'h00, m_byte = 8'h00;
    logic pv = 1'b0, pbusy = 1'b0;
    logic [7:0] pd = 8'h00;
    logic [7:0] hello [8] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h21, 8'h0A};
    bit rand_done;

    uart_receiver #(.clocks_per_bit(CPB)) dut (
        .ser_clk  (ser_clk),
        .rst_n    (rst_n),
        .ser_rx   (ser_rx),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .err_clear(err_clear),
        .rx_busy  (rx_busy)
    );

    always #5 ser_clk = ~ser_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Model: rx_s is the line delayed two edges; a frame is judged by edge offsets from START entry
    always @(posedge ser_clk) begin
        logic samp, s_ok, s_bad;
        int k;
        #1;
        cyc++;
        if (!rst_n) begin
            m_mode = 0; m_t = 0; m_d1 = 1'b1; m_d2 = 1'b1;
            m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
        end else begin
            samp = m_d2; m_d2 = m_d1; m_d1 = ser_rx;
            s_ok = 1'b0; s_bad = 1'b0;
            if (m_mode == 0) begin
                if (!samp) begin m_mode = 1; m_t = 0; end
            end else if (m_mode == 1) begin
                m_t++;
                if (m_t == H) begin
                    if (samp) m_mode = 0;
                end else if (m_t > H && (m_t - H) % CPB == 0) begin
                    k = (m_t - H) / CPB;
                    if (k <= 8) m_byte[k-1] = samp;
                    else begin
                        m_mode = samp ? 0 : 2;
                        s_ok = samp;
                        s_bad = !samp;
                    end
                end
            end else if (samp) m_mode = 0;
            if (s_ok && m_valid && !out_ready) m_ovr = 1'b1;
            else if (err_clear) m_ovr = 1'b0;
            if (s_bad) m_ferr = 1'b1;
            else if (err_clear) m_ferr = 1'b0;
            if (s_ok && (!m_valid || out_ready)) begin
                m_valid = 1'b1;
                m_data = m_byte;
            end else if (m_valid && out_ready) m_valid = 1'b0;
            if (pv && out_ready) rx_q.push_back(pd);
        end
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("rx_busy", 32'(rx_busy), 32'(m_mode != 0));
        if (out_valid && !pv) begin valid_rises++; last_rise = cyc; end
        if (!rx_busy && pbusy) last_busy_fall = cyc;
        pv = out_valid; pd = out_data; pbusy = rx_busy;
    end

    task automatic hold(input logic b, input int n);
        ser_rx = b;
        repeat (n) @(negedge ser_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int stop_len);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(stop_b, stop_len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int fall, vr, m;
        @(negedge ser_clk);
        check("reset_out_data", 32'(out_data), 32'h0);
        check("reset_flags", 32'({out_valid, frame_err, overrun, rx_busy}), 32'h0);
        repeat (2) @(negedge ser_clk);
        rst_n = 1'b1;
        hold(1'b1, 5);
        // single byte latency
        rx_q.delete();
        fall = cyc + 1;
        send_frame(8'h48, 1'b1, CPB);
        hold(1'b1, 8);
        check("t1_latency", 32'(last_rise - fall), 32'd40);
        check("t1_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("t1_data", 32'(rx_q[0]), 32'h48);
        // back-to-back frames
        rx_q.delete();
        foreach (hello[i]) send_frame(hello[i], 1'b1, CPB);
        hold(1'b1, 8);
        check("t2_count", 32'(rx_q.size()), 32'd8);
        foreach (hello[i]) if (i < rx_q.size()) check("t2_data", 32'(rx_q[i]), 32'(hello[i]));
        check("t2_flags", 32'({frame_err, overrun}), 32'h0);
        // start glitch
        vr = valid_rises;
        fall = cyc + 1;
        hold(1'b0, H - 1);
        hold(1'b1, 10);
        check("t3_busy_fall", 32'(last_busy_fall - fall), 32'(H + 2));
        check("t3_no_valid", 32'(valid_rises - vr), 32'd0);
        check("t3_flags", 32'({frame_err, overrun}), 32'h0);
        // framing error and break
        vr = valid_rises;
        send_frame(8'h55, 1'b0, CPB + 30);
        check("t4_busy_in_break", 32'(rx_busy), 32'd1);
        m = cyc + 1;
        hold(1'b1, 6);
        check("t4_busy_fall", 32'(last_busy_fall - m), 32'd2);
        check("t4_frame_err", 32'(frame_err), 32'd1);
        check("t4_no_valid", 32'(valid_rises - vr), 32'd0);
        err_clear = 1'b1;
        @(negedge ser_clk);
        err_clear = 1'b0;
        check("t4_cleared", 32'(frame_err), 32'd0);
        // overrun
        rx_q.delete();
        out_ready = 1'b0;
        send_frame(8'hA5, 1'b1, CPB);
        send_frame(8'h3C, 1'b1, CPB);
        hold(1'b1, 8);
        check("t5_data", 32'(out_data), 32'hA5);
        check("t5_valid", 32'(out_valid), 32'd1);
        check("t5_overrun", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        @(negedge ser_clk);
        out_ready = 1'b0;
        check("t5_valid_fell", 32'(out_valid), 32'd0);
        hold(1'b1, 10);
        check("t5_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("t5_accepted", 32'(rx_q[0]), 32'hA5);
        err_clear = 1'b1;
        @(negedge ser_clk);
        err_clear = 1'b0;
        out_ready = 1'b1;
        check("t5_cleared", 32'(overrun), 32'd0);
        // reset mid-frame
        rx_q.delete();
        send_frame(8'h00, 1'b1, 0);
        ser_rx = 1'b0;
        repeat (2 * CPB) @(negedge ser_clk);
        hold(1'b0, 3);
        check("t6_busy_before", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        ser_rx = 1'b1;
        #1;
        check("t6_reset_out", 32'({out_valid, frame_err, overrun, rx_busy}), 32'h0);
        check("t6_reset_data", 32'(out_data), 32'h0);
        repeat (3) @(negedge ser_clk);
        rst_n = 1'b1;
        hold(1'b1, 5);
        send_frame(8'hFF, 1'b1, CPB);
        hold(1'b1, 8);
        check("t6_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("t6_data", 32'(rx_q[0]), 32'hFF);
        // randomized traffic with random ready, clears, glitches and bad stops
        rand_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    int kind = $urandom_range(0, 9);
                    if (kind == 0) hold(1'b0, $urandom_range(1, H));
                    else if (kind == 1) send_frame(8'($urandom), 1'b0, CPB + $urandom_range(0, 12));
                    else send_frame(8'($urandom), 1'b1, CPB);
                    hold(1'b1, $urandom_range(0, 4));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    err_clear = ($urandom_range(0, 15) == 0);
                    @(negedge ser_clk);
                end
            end
        join
        out_ready = 1'b1;
        err_clear = 1'b0;
        hold(1'b1, 20);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
